// File: rtl/io_cfg_pkg.sv
// Shared encodings, FSM state constants and IO-side helpers for the IO column
// configuration loader.
package io_cfg_pkg;

  // TSMUX: 00 tristated, 01 follows the block's output-enable, 1x always driven.
  localparam logic [1:0] TS_OFF  = 2'b00;
  localparam logic [1:0] TS_CTRL = 2'b01;
  localparam logic [1:0] TS_ON   = 2'b10;

  localparam logic IN_DIRECT = 1'b0;
  localparam logic IN_REG    = 1'b1;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_HUNT = 2'd0;
  localparam fsm_state_t ST_ADDR = 2'd1;
  localparam fsm_state_t ST_DATA = 2'd2;
  localparam fsm_state_t ST_PAR  = 2'd3;

  // Pad driver enable as an IO block resolves it from its TSMUX setting.
  function automatic logic tsmux_oe(input logic [1:0] ts, input logic ctrl_oe);
    logic oe;
    case (ts)
      TS_OFF:  oe = 1'b0;
      TS_CTRL: oe = ctrl_oe;
      TS_ON:   oe = 1'b1;
      default: oe = 1'b1;
    endcase
    return oe;
  endfunction

  function automatic logic dorreg_pick(input logic sel, input logic direct, input logic registered);
    return (sel == IN_REG) ? registered : direct;
  endfunction

endpackage

// File: rtl/io_cfg_frame_rx.sv
// Serial frame receiver: hunts the sync word, then collects address, data and
// parity, and strobes either a write or an error on the parity-bit edge.
module io_cfg_frame_rx
  import io_cfg_pkg::*;
#(
  parameter int         NUM_IO    = 6,
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              din,
  input  logic              en,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        data,
  output logic              wr_stb,
  output logic              err_stb
);

  localparam int CNT_W = $clog2(ADDR_W + 3);

  fsm_state_t        state_reg, state_next;
  logic [7:0]        sync_reg, sync_next;
  logic [7:0]        sync_shift;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        data_reg, data_next;
  logic              par_reg, par_next;
  logic              busy_reg;
  logic              par_ok;
  logic              addr_ok;

  // The comparison includes the bit arriving this cycle, so overlapping
  // patterns are found without losing a bit.
  assign sync_shift = {sync_reg[6:0], din};
  assign par_ok     = ~(par_reg ^ din);
  assign addr_ok    = {1'b0, addr_reg} < (ADDR_W + 1)'(NUM_IO);

  always_comb begin
    state_next = state_reg;
    sync_next  = sync_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    par_next   = par_reg;
    wr_stb     = 1'b0;
    err_stb    = 1'b0;
    if (en) begin
      case (state_reg)
        ST_HUNT: begin
          sync_next = sync_shift;
          if (sync_shift == SYNC_WORD) begin
            state_next = ST_ADDR;
            cnt_next   = '0;
            par_next   = 1'b0;
          end
        end
        ST_ADDR: begin
          addr_next = ADDR_W'({addr_reg, din});
          par_next  = par_reg ^ din;
          if (cnt_reg == CNT_W'(ADDR_W - 1)) begin
            state_next = ST_DATA;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_DATA: begin
          data_next = {data_reg[1:0], din};
          par_next  = par_reg ^ din;
          if (cnt_reg == CNT_W'(2)) begin
            state_next = ST_PAR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_HUNT;
          sync_next  = '0;
          if (par_ok && addr_ok) begin
            wr_stb = 1'b1;
          end else begin
            err_stb = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_HUNT;
      sync_reg  <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      par_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= sync_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      par_reg   <= par_next;
      busy_reg  <= (state_next != ST_HUNT);
    end
  end

  assign busy = busy_reg;
  assign addr = addr_reg;
  assign data = data_reg;

endmodule

// File: rtl/io_config_loader.sv
// IO column configuration loader: decodes serial frames and holds the per-block
// TSMUX / DORREG settings plus the write-acknowledge and sticky error flags.
module io_config_loader
  import io_cfg_pkg::*;
#(
  parameter int         NUM_IO    = 6,
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic                  IOCLK,
  input  logic                  RST,
  input  logic                  CFG_DIN,
  input  logic                  CFG_EN,
  input  logic                  ERR_CLR,
  output logic [2*NUM_IO-1:0]   CFG_TSMUX,
  output logic [NUM_IO-1:0]     CFG_DORREG,
  output logic                  BUSY,
  output logic                  WR_ACK,
  output logic                  ERR
);

  logic [ADDR_W-1:0] rx_addr;
  logic [2:0]        rx_data;
  logic              rx_wr_stb;
  logic              rx_err_stb;
  logic              wr_ack_reg;
  logic              err_reg;

  io_cfg_frame_rx #(
    .NUM_IO    (NUM_IO),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_frame_rx (
    .clk     (IOCLK),
    .srst    (RST),
    .din     (CFG_DIN),
    .en      (CFG_EN),
    .busy    (BUSY),
    .addr    (rx_addr),
    .data    (rx_data),
    .wr_stb  (rx_wr_stb),
    .err_stb (rx_err_stb)
  );

  // rx_data[2:1] is the TSMUX field and rx_data[0] the DORREG bit, in arrival order.
  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_slot
    logic [1:0] ts_reg;
    logic       dr_reg;

    always_ff @(posedge IOCLK) begin
      if (RST) begin
        ts_reg <= TS_OFF;
        dr_reg <= IN_DIRECT;
      end else if (rx_wr_stb && (rx_addr == ADDR_W'(gi))) begin
        ts_reg <= rx_data[2:1];
        dr_reg <= rx_data[0];
      end
    end

    assign CFG_TSMUX[2*gi+1:2*gi] = ts_reg;
    assign CFG_DORREG[gi]         = dr_reg;
  end

  // A new error wins over a simultaneous clear so no error is ever lost.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      wr_ack_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      wr_ack_reg <= rx_wr_stb;
      if (rx_err_stb) begin
        err_reg <= 1'b1;
      end else if (ERR_CLR) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign WR_ACK = wr_ack_reg;
  assign ERR    = err_reg;

endmodule

// File: tb/tb_io_config_loader.sv
// Self-checking bench for io_config_loader: directed scenarios plus randomized
// frames with noise and gaps, compared against a slot-array reference model.
module tb_io_config_loader;

  localparam int NUM_IO = 6;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                din;
  logic                en;
  logic                clr;
  logic [2*NUM_IO-1:0] tsmux;
  logic [NUM_IO-1:0]   dorreg;
  logic                busy;
  logic                ack;
  logic                err;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_ts [NUM_IO];
  logic       m_dr [NUM_IO];
  logic       m_err;

  always #5 clk = ~clk;

  io_config_loader #(
    .NUM_IO    (NUM_IO),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (8'hA5)
  ) dut (
    .IOCLK      (clk),
    .RST        (rst),
    .CFG_DIN    (din),
    .CFG_EN     (en),
    .ERR_CLR    (clr),
    .CFG_TSMUX  (tsmux),
    .CFG_DORREG (dorreg),
    .BUSY       (busy),
    .WR_ACK     (ack),
    .ERR        (err)
  );

  function automatic logic [2*NUM_IO-1:0] exp_ts();
    logic [2*NUM_IO-1:0] r;
    for (int i = 0; i < NUM_IO; i++) r[2*i +: 2] = m_ts[i];
    return r;
  endfunction

  function automatic logic [NUM_IO-1:0] exp_dr();
    logic [NUM_IO-1:0] r;
    for (int i = 0; i < NUM_IO; i++) r[i] = m_dr[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_IO; i++) begin
      m_ts[i] = 2'b00;
      m_dr[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic c);
    din = b;
    en  = 1'b1;
    clr = c;
    step();
    en  = 1'b0;
    clr = 1'b0;
    din = 1'($urandom);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      en  = 1'b0;
      din = 1'($urandom);
      step();
    end
  endtask

  // Drives one whole frame; a gap of gap_len idle cycles precedes bit gap_at
  // (14 = first sync bit ... 0 = parity). busy_mid is BUSY just before the gap.
  task automatic send_frame(input int a, input logic [1:0] t, input logic d, input logic badp,
                            input int gap_at, input int gap_len, input logic clr_last,
                            output logic good, output logic busy_mid);
    logic [2:0]  av;
    logic        p;
    logic [14:0] fr;
    av = a[2:0];
    p  = (($countones({av, t, d}) % 2) == 1) ^ badp;
    fr = {8'hA5, av, t, d, p};
    busy_mid = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (i == gap_at) begin
        busy_mid = busy;
        gap(gap_len);
      end
      send_bit(fr[i], (i == 0) && clr_last);
    end
    good = !badp && (a < NUM_IO);
    if (good) begin
      m_ts[a] = t;
      m_dr[a] = d;
    end
    if (!good) m_err = 1'b1;
    else if (clr_last) m_err = 1'b0;
    $display("frame addr=%0d ts=%b dr=%b badpar=%b gap@%0d len=%0d -> good=%b", a, t, d, badp, gap_at, gap_len, good);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    gap(3);
    total++;
    if ({tsmux, dorreg, busy, ack, err} !== {12'h000, 6'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset: got ts=%h dr=%h busy=%b ack=%b err=%b want all zero", tsmux, dorreg, busy, ack, err);
    end
  endtask

  task automatic test_write();
    logic g, bm;
    send_frame(2, 2'b01, 1'b1, 1'b0, 6, 0, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg, ack, busy, err} !== {12'h010, 6'h04, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL write: got ts=%h dr=%h ack=%b busy=%b err=%b want ts=010 dr=04 ack=1 busy=0 err=0", tsmux, dorreg, ack, busy, err);
    end
    total++;
    if (bm !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_sync: got %b want 1", bm);
    end
    step();
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL ack_one_cycle: got %b want 0", ack);
    end
  endtask

  task automatic test_bad_parity();
    logic g, bm;
    send_frame(2, 2'b11, 1'b0, 1'b1, 15, 2, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg, ack, err, bm} !== {exp_ts(), exp_dr(), 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bad_parity: got ts=%h dr=%h ack=%b err=%b busy_pre=%b want ts=%h dr=%h ack=0 err=1 busy_pre=0",
               tsmux, dorreg, ack, err, bm, exp_ts(), exp_dr());
    end
    gap(3);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    clr = 1'b1; step(); clr = 1'b0;
    m_err = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b want 0", err);
    end
  endtask

  task automatic test_bad_addr();
    logic g, bm;
    send_frame(7, 2'b10, 1'b0, 1'b0, 0, 0, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg, ack, err} !== {exp_ts(), exp_dr(), 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL bad_addr: got ts=%h dr=%h ack=%b err=%b want ts=%h dr=%h ack=0 err=1", tsmux, dorreg, ack, err, exp_ts(), exp_dr());
    end
    // Clear colliding with a fresh error must leave ERR set.
    send_frame(6, 2'b01, 1'b1, 1'b0, 3, 1, 1'b1, g, bm);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_clr_collision: got %b want 1", err);
    end
    clr = 1'b1; step(); clr = 1'b0;
    m_err = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr2: got %b want 0", err);
    end
  endtask

  task automatic test_gap();
    logic g, bm;
    send_frame(5, 2'b10, 1'b1, 1'b0, 5, 4, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg, ack, err, bm} !== {12'h810, 6'h24, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL gap_mid_addr: got ts=%h dr=%h ack=%b err=%b busy_gap=%b want ts=810 dr=24 ack=1 err=0 busy_gap=1",
               tsmux, dorreg, ack, err, bm);
    end
    send_frame(5, 2'b01, 1'b0, 1'b0, 1, 3, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg} !== {exp_ts(), exp_dr()}) begin
      bad++;
      $display("FAIL overwrite: got ts=%h dr=%h want ts=%h dr=%h", tsmux, dorreg, exp_ts(), exp_dr());
    end
  endtask

  task automatic test_rst_mid();
    logic        g, bm;
    logic [13:0] part;
    part = {8'hA5, 3'b001, 2'b10, 1'b1};
    for (int i = 13; i >= 1; i--) send_bit(part[i], 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_data: got %b want 1", busy);
    end
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    total++;
    if ({tsmux, dorreg, busy, ack, err} !== {12'h000, 6'h00, 3'b000}) begin
      bad++;
      $display("FAIL rst_mid: got ts=%h dr=%h busy=%b ack=%b err=%b want all zero", tsmux, dorreg, busy, ack, err);
    end
    send_frame(1, 2'b11, 1'b1, 1'b0, 15, 0, 1'b0, g, bm);
    total++;
    if ({tsmux, dorreg, ack, err} !== {12'h00C, 6'h02, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL after_rst: got ts=%h dr=%h ack=%b err=%b want ts=00c dr=02 ack=1 err=0", tsmux, dorreg, ack, err);
    end
  endtask

  task automatic test_random();
    logic g, bm;
    for (int n = 0; n < 40; n++) begin
      gap(int'($urandom_range(0, 3)));
      for (int z = int'($urandom_range(0, 4)); z > 0; z--) send_bit(1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      end
      send_frame(int'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), g, bm);
      total++;
      if ({tsmux, dorreg, ack, err, busy} !== {exp_ts(), exp_dr(), g, m_err, 1'b0}) begin
        bad++;
        $display("FAIL random[%0d]: got ts=%h dr=%h ack=%b err=%b busy=%b want ts=%h dr=%h ack=%b err=%b busy=0",
                 n, tsmux, dorreg, ack, err, busy, exp_ts(), exp_dr(), g, m_err);
      end
      if ($urandom_range(0, 2) == 0) begin
        clr = 1'b1; step(); clr = 1'b0;
        m_err = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_parity();
    test_bad_addr();
    test_gap();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
